// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, drives the PISO frame generator's load/shift
// controls and serialises the held frame onto tx, start bit first.
module uart_tx_ctrl #(
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic        baud_clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [7:0]  tx_data,
  input  logic [10:0] frame_in,
  output logic [7:0]  frame_data,
  output logic        frame_parity,
  output logic        shift,
  output logic        load,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [3:0]  bit_idx
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StStop2} state_e;

  localparam logic [3:0] LastBit = 4'd10;

  state_e      state_q;
  logic [7:0]  frame_data_q;
  logic [3:0]  bit_idx_q;
  logic        tx_done_q;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      frame_data_q <= '0;
      bit_idx_q    <= '0;
      tx_done_q    <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_start) begin
            frame_data_q <= tx_data;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          bit_idx_q <= '0;
          state_q   <= StSend;
        end
        StSend: begin
          if (bit_idx_q == LastBit) begin
            bit_idx_q <= '0;
            if (STOP_BITS == 2) begin
              state_q <= StStop2;
            end else begin
              state_q   <= StIdle;
              tx_done_q <= 1'b1;
            end
          end else begin
            bit_idx_q <= bit_idx_q + 4'd1;
          end
        end
        StStop2: begin
          state_q   <= StIdle;
          tx_done_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Parity follows the latched byte, so it is already settled when LOAD presents it.
  assign frame_parity = (^frame_data_q) ^ PARITY_ODD;
  assign frame_data   = frame_data_q;
  assign bit_idx      = bit_idx_q;
  assign tx_done      = tx_done_q;

  assign load    = (state_q == StLoad);
  assign shift   = (state_q == StSend) || (state_q == StStop2);
  assign tx_busy = (state_q != StIdle);
  assign tx      = (state_q == StSend) ? frame_in[bit_idx_q] : 1'b1;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: three configurations (even/1 stop, odd/1 stop,
// even/2 stop), each fed by a behavioural model of the PISO frame generator.
module tb_uart_tx_ctrl;

  logic        baud_clk;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic        start_v      [3];
  logic [10:0] frame_q      [3];
  logic [7:0]  frame_data_w [3];
  logic        parity_w     [3];
  logic        shift_w      [3];
  logic        load_w       [3];
  logic        tx_w         [3];
  logic        busy_w       [3];
  logic        done_w       [3];
  logic [3:0]  bit_idx_w    [3];

  bit odd_cfg  [3] = '{1'b0, 1'b1, 1'b0};
  int stop_cfg [3] = '{1, 1, 2};

  int checks   = 0;
  int failures = 0;

  uart_tx_ctrl #(.PARITY_ODD(1'b0), .STOP_BITS(1)) dut_even (
    .baud_clk(baud_clk), .rst_n(rst_n), .tx_start(start_v[0]), .tx_data(tx_data),
    .frame_in(frame_q[0]), .frame_data(frame_data_w[0]), .frame_parity(parity_w[0]),
    .shift(shift_w[0]), .load(load_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
    .tx_done(done_w[0]), .bit_idx(bit_idx_w[0])
  );

  uart_tx_ctrl #(.PARITY_ODD(1'b1), .STOP_BITS(1)) dut_odd (
    .baud_clk(baud_clk), .rst_n(rst_n), .tx_start(start_v[1]), .tx_data(tx_data),
    .frame_in(frame_q[1]), .frame_data(frame_data_w[1]), .frame_parity(parity_w[1]),
    .shift(shift_w[1]), .load(load_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
    .tx_done(done_w[1]), .bit_idx(bit_idx_w[1])
  );

  uart_tx_ctrl #(.PARITY_ODD(1'b0), .STOP_BITS(2)) dut_stop2 (
    .baud_clk(baud_clk), .rst_n(rst_n), .tx_start(start_v[2]), .tx_data(tx_data),
    .frame_in(frame_q[2]), .frame_data(frame_data_w[2]), .frame_parity(parity_w[2]),
    .shift(shift_w[2]), .load(load_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]),
    .tx_done(done_w[2]), .bit_idx(bit_idx_w[2])
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  // Frame generator model: reloads every cycle unless shift holds it.
  always @(posedge baud_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!shift_w[i]) frame_q[i] <= {1'b1, parity_w[i], frame_data_w[i], 1'b0};
    end
  end

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  // Bits in the order they must appear on the line.
  function automatic logic [10:0] line_bits(input logic [7:0] d, input bit odd);
    logic [10:0] b;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i + 1] = d[i];
    b[9]  = (($countones(d) % 2) == 1) ^ odd;
    b[10] = 1'b1;
    return b;
  endfunction

  // Starts a frame on unit u from an idle post-edge point and checks every cycle of it;
  // optionally pulses tx_start with busy_d during SEND cycle busy_cyc.
  task automatic send_frame(input int u, input logic [7:0] d, input int busy_cyc,
                            input logic [7:0] busy_d);
    logic [10:0] bits;
    bits       = line_bits(d, odd_cfg[u]);
    tx_data    = d;
    start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    checks++;
    if (load_w[u] !== 1'b1 || busy_w[u] !== 1'b1 || shift_w[u] !== 1'b0) begin
      failures++;
      $display("FAIL load_cycle u%0d: load=%b busy=%b shift=%b, want 1 1 0",
               u, load_w[u], busy_w[u], shift_w[u]);
    end
    checks++;
    if (frame_data_w[u] !== d || parity_w[u] !== bits[9]) begin
      failures++;
      $display("FAIL capture u%0d: frame_data=%h parity=%b, want %h %b",
               u, frame_data_w[u], parity_w[u], d, bits[9]);
    end
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (k == busy_cyc) begin
        start_v[u] = 1'b1;
        tx_data    = busy_d;
      end else if (k == busy_cyc + 1) begin
        start_v[u] = 1'b0;
      end
      checks++;
      if (tx_w[u] !== bits[k - 2] || bit_idx_w[u] !== 4'(k - 2) || busy_w[u] !== 1'b1 ||
          shift_w[u] !== 1'b1 || done_w[u] !== 1'b0) begin
        failures++;
        $display("FAIL send u%0d d=%h cycle %0d: tx=%b idx=%0d busy=%b shift=%b done=%b, want %b %0d 1 1 0",
                 u, d, k, tx_w[u], bit_idx_w[u], busy_w[u], shift_w[u], done_w[u],
                 bits[k - 2], k - 2);
      end
    end
    if (stop_cfg[u] == 2) begin
      tick();
      checks++;
      if (tx_w[u] !== 1'b1 || shift_w[u] !== 1'b1 || busy_w[u] !== 1'b1 ||
          done_w[u] !== 1'b0 || bit_idx_w[u] !== 4'd0) begin
        failures++;
        $display("FAIL stop2 u%0d: tx=%b shift=%b busy=%b done=%b idx=%0d, want 1 1 1 0 0",
                 u, tx_w[u], shift_w[u], busy_w[u], done_w[u], bit_idx_w[u]);
      end
    end
    tick();
    checks++;
    if (done_w[u] !== 1'b1 || busy_w[u] !== 1'b0 || tx_w[u] !== 1'b1 ||
        shift_w[u] !== 1'b0 || load_w[u] !== 1'b0 || frame_data_w[u] !== d) begin
      failures++;
      $display("FAIL done u%0d: done=%b busy=%b tx=%b shift=%b load=%b data=%h, want 1 0 1 0 0 %h",
               u, done_w[u], busy_w[u], tx_w[u], shift_w[u], load_w[u], frame_data_w[u], d);
    end
  endtask

  task automatic check_idle(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (busy_w[u] !== 1'b0 || tx_w[u] !== 1'b1 || done_w[u] !== 1'b0 || load_w[u] !== 1'b0) begin
        failures++;
        $display("FAIL idle u%0d: busy=%b tx=%b done=%b load=%b, want 0 1 0 0",
                 u, busy_w[u], tx_w[u], done_w[u], load_w[u]);
      end
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (tx_w[u] !== 1'b1 || busy_w[u] !== 1'b0 || done_w[u] !== 1'b0 || shift_w[u] !== 1'b0 ||
          load_w[u] !== 1'b0 || bit_idx_w[u] !== 4'd0 || frame_data_w[u] !== 8'h00) begin
        failures++;
        $display("FAIL reset u%0d: tx=%b busy=%b done=%b shift=%b load=%b idx=%0d data=%h, want 1 0 0 0 0 0 00",
                 u, tx_w[u], busy_w[u], done_w[u], shift_w[u], load_w[u], bit_idx_w[u],
                 frame_data_w[u]);
      end
    end
  endtask

  task automatic test_basic();
    send_frame(0, 8'hA5, 0, 8'h00);
    check_idle(0, 2);
  endtask

  task automatic test_odd_parity();
    send_frame(1, 8'h07, 0, 8'h00);
    check_idle(1, 1);
    send_frame(1, 8'h00, 0, 8'h00);
    check_idle(1, 1);
  endtask

  task automatic test_two_stop();
    send_frame(2, 8'hFF, 0, 8'h00);
    check_idle(2, 2);
  endtask

  task automatic test_busy_request();
    send_frame(0, 8'hA5, 5, 8'h3C);
    check_idle(0, 4);
    checks++;
    if (frame_data_w[0] !== 8'hA5) begin
      failures++;
      $display("FAIL busy_ignore: frame_data=%h, want a5", frame_data_w[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1;
    logic [10:0] b2;
    b1         = line_bits(8'h55, 1'b0);
    b2         = line_bits(8'hAA, 1'b0);
    tx_data    = 8'h55;
    start_v[0] = 1'b1;
    tick();
    tx_data = 8'hAA;
    for (int k = 2; k <= 12; k++) begin
      tick();
      checks++;
      if (tx_w[0] !== b1[k - 2]) begin
        failures++;
        $display("FAIL b2b_first cycle %0d: tx=%b, want %b", k, tx_w[0], b1[k - 2]);
      end
    end
    tick();
    checks++;
    if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: done=%b busy=%b, want 1 0", done_w[0], busy_w[0]);
    end
    tick();
    start_v[0] = 1'b0;
    checks++;
    if (load_w[0] !== 1'b1 || frame_data_w[0] !== 8'hAA) begin
      failures++;
      $display("FAIL b2b_load: load=%b data=%h, want 1 aa", load_w[0], frame_data_w[0]);
    end
    for (int k = 15; k <= 25; k++) begin
      tick();
      checks++;
      if (tx_w[0] !== b2[k - 15] || bit_idx_w[0] !== 4'(k - 15)) begin
        failures++;
        $display("FAIL b2b_second cycle %0d: tx=%b idx=%0d, want %b %0d",
                 k, tx_w[0], bit_idx_w[0], b2[k - 15], k - 15);
      end
    end
    tick();
    checks++;
    if (done_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done2: done=%b, want 1", done_w[0]);
    end
    check_idle(0, 1);
  endtask

  task automatic test_reset_mid_frame();
    tx_data    = 8'h3C;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || bit_idx_w[0] !== 4'd0 ||
        shift_w[0] !== 1'b0 || load_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: tx=%b busy=%b done=%b idx=%0d shift=%b load=%b, want 1 0 0 0 0 0",
               tx_w[0], busy_w[0], done_w[0], bit_idx_w[0], shift_w[0], load_w[0]);
    end
    tick();
    rst_n = 1'b1;
    check_idle(0, 2);
    send_frame(0, 8'h81, 0, 8'h00);
    check_idle(0, 1);
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int rep = 0; rep < 4; rep++) begin
      for (int u = 0; u < 3; u++) begin
        d = 8'($urandom);
        send_frame(u, d, 0, 8'h00);
        check_idle(u, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    tx_data = 8'h00;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_odd_parity();
    test_two_stop();
    test_busy_request();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
